// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC: (x, y) -> magnitude, atan2(y, x)
`timescale 1ns/1ps
module cordic_vectoring #(
  parameter int N_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mag_o,
  output logic [31:0] angle_o
);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  // atan(2^-k) in Q2.30
  localparam logic [31:0] ATAN [32] = '{
    32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
    32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
    32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
    32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
    32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
    32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
    32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000008,
    32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
  };
  localparam logic signed [33:0] HALF_PI = 34'sh06487ED51;
  localparam logic signed [33:0] GAIN    = 34'sh026DD3B6A;
  localparam logic [4:0]         K_LAST  = 5'(N_ITER - 1);

  state_t state, next_state;
  logic signed [33:0] x_r, y_r, z_r;
  logic [4:0]         k_r;
  logic               zero_r;

  logic               accept;
  logic signed [33:0] x_ext, y_ext, atan_k, x_sh, y_sh;
  logic signed [67:0] mag_prod;
  logic [31:0]        mag_w, angle_w;

  assign accept   = (state == IDLE) && in_valid && in_ready;
  assign x_ext    = {{2{x_i[31]}}, x_i};
  assign y_ext    = {{2{y_i[31]}}, y_i};
  assign atan_k   = {{2{ATAN[k_r][31]}}, ATAN[k_r]};
  assign x_sh     = x_r >>> k_r;
  assign y_sh     = y_r >>> k_r;
  assign mag_prod = x_r * GAIN;
  assign mag_w    = 32'(mag_prod >>> 30);
  assign angle_w  = 32'(z_r >>> 1);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ITER;
      ITER:    if (k_r == K_LAST) next_state = SCALE;
      SCALE:   next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mag_o     <= '0;
      angle_o   <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      k_r       <= '0;
      zero_r    <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == IDLE);
      case (state)
        IDLE: if (accept) begin
          k_r    <= '0;
          zero_r <= (x_i == 32'd0) && (y_i == 32'd0);
          // Fold left half-plane vectors into the right half-plane by +/-90 degrees
          if (!x_i[31]) begin
            x_r <= x_ext;
            y_r <= y_ext;
            z_r <= '0;
          end else if (!y_i[31]) begin
            x_r <= y_ext;
            y_r <= -x_ext;
            z_r <= HALF_PI;
          end else begin
            x_r <= -y_ext;
            y_r <= x_ext;
            z_r <= -HALF_PI;
          end
        end
        ITER: begin
          k_r <= k_r + 5'd1;
          if (!y_r[33]) begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_k;
          end else begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_k;
          end
        end
        SCALE: begin
          mag_o     <= zero_r ? 32'd0 : mag_w;
          angle_o   <= zero_r ? 32'd0 : angle_w;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - bench for cordic_vectoring: directed table, corner sequences, random vs real model
`timescale 1ns/1ps
module tb_cordic_vectoring;

  localparam int  N_ITER = 32;
  localparam int  LAT    = N_ITER + 1;
  localparam real PI     = 3.14159265358979323846;
  localparam real Q29    = 536870912.0;
  localparam real Q30    = 1073741824.0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x_i = '0;
  logic [31:0] y_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] mag_o;
  logic [31:0] angle_o;

  always #5 clk = ~clk;

  cordic_vectoring #(.N_ITER(N_ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .y_i(y_i), .out_valid(out_valid), .out_ready(out_ready),
    .mag_o(mag_o), .angle_o(angle_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] mag;
    logic [31:0] ang;
    bit          exact;
  } vec_t;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    longint d;
    d = longint'($signed(act)) - longint'($signed(exp));
    check(d <= tol && d >= -tol, name, longint'($signed(act)), longint'($signed(exp)));
  endtask

  // Reference: exact polar form from plain real arithmetic
  function automatic void polar_model(input int signed xv, input int signed yv, output real m, output real a);
    real xr, yr;
    xr = $itor(xv) / Q30;
    yr = $itor(yv) / Q30;
    m  = $sqrt(xr * xr + yr * yr) * Q30;
    a  = $atan2(yr, xr) * Q29;
  endfunction

  task automatic run_vector(input logic [31:0] vx, input logic [31:0] vy,
                            output logic [31:0] m, output logic [31:0] a);
    int w;
    int lat;
    m = '0;
    a = '0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    x_i = vx;
    y_i = vy;
    @(posedge clk);
    @(negedge clk);
    // in_valid stays high with junk data: must be ignored while busy
    x_i = $urandom;
    y_i = $urandom;
    check(in_ready == 1'b0, "in_ready_busy", longint'(in_ready), 0);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check(out_valid == 1'b1 && lat == LAT, "latency", lat, LAT);
    m = mag_o;
    a = angle_o;
    if (out_ready) begin
      @(negedge clk);
      check(out_valid == 1'b0 && in_ready == 1'b1, "release_to_idle",
            longint'({out_valid, in_ready}), 1);
    end
  endtask

  vec_t vecs [10];

  initial begin
    logic [31:0] m, a, hm, ha;
    real rm, ra, d;
    int signed xv, yv;

    vecs[0] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[1] = '{32'h00000000, 32'h40000000, 32'h40000000, 32'h3243F6A8, 1'b0};
    vecs[2] = '{32'hC0000000, 32'h00000000, 32'h40000000, 32'h6487ED51, 1'b0};
    vecs[3] = '{32'hC0000000, 32'hFFFFFFFF, 32'h40000000, 32'h9B7812B0, 1'b0};
    vecs[4] = '{32'h2D413CCD, 32'h2D413CCD, 32'h40000000, 32'h1921FB54, 1'b0};
    vecs[5] = '{32'hD2BEC333, 32'h2D413CCD, 32'h40000000, 32'h4B65F1FD, 1'b0};
    vecs[6] = '{32'hD2BEC333, 32'hD2BEC333, 32'h40000000, 32'hB49A0E03, 1'b0};
    vecs[7] = '{32'h2D413CCD, 32'hD2BEC333, 32'h40000000, 32'hE6DE04AC, 1'b0};
    vecs[8] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
    vecs[9] = '{32'h00000000, 32'hC0000000, 32'h40000000, 32'hCDBC0958, 1'b0};

    repeat (3) @(negedge clk);
    check(in_ready == 1'b0, "rst_in_ready", longint'(in_ready), 0);
    check(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
    check(mag_o == 32'd0, "rst_mag", longint'(mag_o), 0);
    check(angle_o == 32'd0, "rst_angle", longint'(angle_o), 0);
    rst_n = 1'b1;
    #1;
    check(in_ready == 1'b0, "in_ready_before_edge", longint'(in_ready), 0);
    @(negedge clk);
    check(in_ready == 1'b1, "in_ready_after_edge", longint'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_vector(vecs[i].x, vecs[i].y, m, a);
      if (vecs[i].exact) begin
        check(m == vecs[i].mag, $sformatf("vec%0d_mag", i), longint'(m), longint'(vecs[i].mag));
        check(a == vecs[i].ang, $sformatf("vec%0d_angle", i), longint'(a), longint'(vecs[i].ang));
      end else begin
        check_tol($sformatf("vec%0d_mag", i), m, vecs[i].mag, 16);
        check_tol($sformatf("vec%0d_angle", i), a, vecs[i].ang, 16);
      end
    end

    // Abort mid-iteration: result must vanish and never be presented
    in_valid = 1'b1;
    x_i = 32'h2D413CCD;
    y_i = 32'h2D413CCD;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "abort_out_valid", longint'(out_valid), 0);
    check(in_ready == 1'b0, "abort_in_ready", longint'(in_ready), 0);
    check(mag_o == 32'd0, "abort_mag", longint'(mag_o), 0);
    check(angle_o == 32'd0, "abort_angle", longint'(angle_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(in_ready == 1'b0, "abort_in_ready_release", longint'(in_ready), 0);
    @(negedge clk);
    check(in_ready == 1'b1 && out_valid == 1'b0, "abort_recover",
          longint'({in_ready, out_valid}), 2);
    run_vector(32'hD2BEC333, 32'h2D413CCD, m, a);
    check_tol("post_abort_mag", m, 32'h40000000, 16);
    check_tol("post_abort_angle", a, 32'h4B65F1FD, 16);

    // Zero vector with consumer stalled for 10 cycles
    out_ready = 1'b0;
    run_vector(32'h00000000, 32'h00000000, hm, ha);
    check(hm == 32'd0 && ha == 32'd0, "hold_zero_result", longint'({hm, ha}), 0);
    in_valid = 1'b1;
    x_i = 32'h40000000;
    y_i = 32'h00000000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check(out_valid == 1'b1, "hold_out_valid", longint'(out_valid), 1);
      check(mag_o == hm && angle_o == ha, "hold_outputs", longint'({mag_o, angle_o}), longint'({hm, ha}));
      check(in_ready == 1'b0, "hold_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check(out_valid == 1'b0 && in_ready == 1'b1, "hold_release",
          longint'({out_valid, in_ready}), 1);

    for (int r = 0; r < 40; r++) begin
      do begin
        xv = int'($urandom_range(0, 32'h7FFFFFFF)) - 32'sh40000000;
        yv = int'($urandom_range(0, 32'h7FFFFFFF)) - 32'sh40000000;
        polar_model(xv, yv, rm, ra);
      end while (rm < 0.25 * Q30);
      run_vector(xv, yv, m, a);
      d = $itor($signed(m)) - rm;
      check(d <= 16.0 && d >= -16.0, $sformatf("rand%0d_mag", r), longint'($signed(m)), longint'($rtoi(rm)));
      d = $itor($signed(a)) - ra;
      if (d > PI * Q29) d = d - 2.0 * PI * Q29;
      if (d < -PI * Q29) d = d + 2.0 * PI * Q29;
      check(d <= 16.0 && d >= -16.0, $sformatf("rand%0d_angle", r), longint'($signed(a)), longint'($rtoi(ra)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
